// File: rtl/mock_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mock_cpu_pkg
//  Description : Shared types and default constants for the mock_cpu
//                pipeline and its downstream signature checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package mock_cpu_pkg;

    // Signature checker run states
    typedef enum logic [1:0] {
        SIG_IDLE     = 2'd0,
        SIG_FLUSH    = 2'd1,
        SIG_COMPRESS = 2'd2,
        SIG_DONE     = 2'd3
    } sig_state_e;

    // CRC-32 generator taps used as the default MISR feedback
    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;
    // All-ones seed so that a run of zero samples still yields a non-zero value
    localparam logic [31:0] MISR_SEED_DEFAULT = 32'hFFFFFFFF;

endpackage : mock_cpu_pkg
`default_nettype wire

// File: rtl/misr_step.sv
`default_nettype none
// ============================================================================
//  Module      : misr_step
//  Description : Combinational single-step MISR next-state function:
//                shift left, fold back the taps when the MSB falls out,
//                then XOR in the parallel input word.
//  Revision    : 1.0 - initial release
// ============================================================================
module misr_step
    import mock_cpu_pkg::*;
#(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(MISR_POLY_DEFAULT)
) (
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig_out
);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_feedback;

    assign w_shifted  = {sig_in[WIDTH-2:0], 1'b0};
    assign w_feedback = sig_in[WIDTH-1] ? POLY : '0;
    assign sig_out    = w_shifted ^ w_feedback ^ data_in;

endmodule : misr_step
`default_nettype wire

// File: rtl/mock_cpu_sig_checker.sv
`default_nettype none
// ============================================================================
//  Module      : mock_cpu_sig_checker
//  Description : Skips the CPU pipeline flush, compresses a programmable
//                number of data_out samples into a MISR and flags whether
//                the final signature equals a latched golden value.
//  Revision    : 1.0 - initial release
// ============================================================================
module mock_cpu_sig_checker
    import mock_cpu_pkg::*;
#(
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      FLUSH_CYCLES = 6,
    parameter int                      CNT_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0]   MISR_POLY    = DATA_WIDTH'(MISR_POLY_DEFAULT),
    parameter logic [DATA_WIDTH-1:0]   MISR_SEED    = DATA_WIDTH'(MISR_SEED_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  match,
    output logic [DATA_WIDTH-1:0] signature,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    // The flush counter loads F-1 and the FLUSH state exits on zero,
    // giving exactly F discarded cycles.
    localparam int              C_FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [C_FC_W-1:0] C_FLUSH_LOAD =
        C_FC_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

    sig_state_e              r_state;
    sig_state_e              w_start_state;
    logic [DATA_WIDTH-1:0]   r_signature;
    logic [DATA_WIDTH-1:0]   r_expected;
    logic [CNT_WIDTH-1:0]    r_num_samples;
    logic [CNT_WIDTH-1:0]    r_sample_count;
    logic [C_FC_W-1:0]       r_flush_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   w_sig_next;
    logic [CNT_WIDTH-1:0]    w_count_inc;

    misr_step #(
        .WIDTH (DATA_WIDTH),
        .POLY  (MISR_POLY)
    ) u_misr_step (
        .sig_in  (r_signature),
        .data_in (data_in),
        .sig_out (w_sig_next)
    );

    assign w_count_inc = r_sample_count + CNT_WIDTH'(1);

    // Destination of an accepted start: empty runs finish at once,
    // otherwise skip the flush phase only when it has zero length.
    always_comb begin
        w_start_state = SIG_FLUSH;
        if (num_samples == '0) begin
            w_start_state = SIG_DONE;
        end else if (FLUSH_CYCLES == 0) begin
            w_start_state = SIG_COMPRESS;
        end
    end

    // Run-control FSM with its counters, latches and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= SIG_IDLE;
            r_signature    <= MISR_SEED;
            r_expected     <= '0;
            r_num_samples  <= '0;
            r_sample_count <= '0;
            r_flush_cnt    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                SIG_IDLE, SIG_DONE: begin
                    if (start) begin
                        r_state        <= w_start_state;
                        r_signature    <= MISR_SEED;
                        r_sample_count <= '0;
                        r_num_samples  <= num_samples;
                        r_expected     <= expected;
                        r_flush_cnt    <= C_FLUSH_LOAD;
                        r_busy         <= (w_start_state != SIG_DONE);
                        r_done         <= (w_start_state == SIG_DONE);
                    end
                end

                SIG_FLUSH: begin
                    if (r_num_samples == '0) begin
                        r_state <= SIG_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_flush_cnt == '0) begin
                        r_state <= SIG_COMPRESS;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - C_FC_W'(1);
                    end
                end

                SIG_COMPRESS: begin
                    r_signature    <= w_sig_next;
                    r_sample_count <= w_count_inc;
                    if (w_count_inc == r_num_samples) begin
                        r_state <= SIG_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= SIG_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign signature    = r_signature;
    assign sample_count = r_sample_count;
    // Single comparator between two registers, gated by the registered done
    assign match        = r_done && (r_signature == r_expected);

endmodule : mock_cpu_sig_checker
`default_nettype wire

// File: tb/tb_mock_cpu_sig_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mock_cpu_sig_checker
//  Description : Directed self-checking bench for mock_cpu_sig_checker.
//                dut0: F=0, seed 0.  dut1: F=6, default seed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mock_cpu_sig_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [15:0] num_samples;
    logic [31:0] expected;
    logic [31:0] data_in;

    logic        busy0, done0, match0;
    logic [31:0] sig0;
    logic [15:0] cnt0;
    logic        busy1, done1, match1;
    logic [31:0] sig1;
    logic [15:0] cnt1;

    int vectors     = 0;
    int miscompares = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    mock_cpu_sig_checker #(
        .FLUSH_CYCLES (0),
        .MISR_SEED    (32'h0)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start0),
        .num_samples  (num_samples),
        .expected     (expected),
        .data_in      (data_in),
        .busy         (busy0),
        .done         (done0),
        .match        (match0),
        .signature    (sig0),
        .sample_count (cnt0)
    );

    mock_cpu_sig_checker dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start1),
        .num_samples  (num_samples),
        .expected     (expected),
        .data_in      (data_in),
        .busy         (busy1),
        .done         (done1),
        .match        (match1),
        .signature    (sig1),
        .sample_count (cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start0      = 1'b0;
        start1      = 1'b0;
        num_samples = '0;
        expected    = '0;
        data_in     = '0;
        tick();
        tick();

        // Reset state of both instances
        chk("rst_sig0",   sig0,   32'h0);
        chk("rst_sig1",   sig1,   32'hFFFFFFFF);
        chk("rst_cnt0",   {16'h0, cnt0}, 32'h0);
        chk("rst_busy0",  {31'h0, busy0}, 32'h0);
        chk("rst_done1",  {31'h0, done1}, 32'h0);
        chk("rst_match1", {31'h0, match1}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Seed 0, F=0, N=3 hand-computed run
        start0 = 1'b1; num_samples = 16'd3; expected = 32'h04C11DB3;
        tick();
        start0 = 1'b0;
        chk("t1_busy_start", {31'h0, busy0}, 32'h1);
        chk("t1_sig_seed",   sig0, 32'h0);
        data_in = 32'h00000001; tick();
        chk("t1_sig_a", sig0, 32'h00000001);
        data_in = 32'h80000000; tick();
        chk("t1_sig_b", sig0, 32'h80000002);
        chk("t1_done_early", {31'h0, done0}, 32'h0);
        data_in = 32'h00000000; tick();
        chk("t1_sig_c",  sig0, 32'h04C11DB3);
        chk("t1_cnt",    {16'h0, cnt0}, 32'd3);
        chk("t1_done",   {31'h0, done0}, 32'h1);
        chk("t1_busy",   {31'h0, busy0}, 32'h0);
        chk("t1_match",  {31'h0, match0}, 32'h1);
        tick();
        chk("t1_frozen", sig0, 32'h04C11DB3);

        // Restart from DONE, then a stray start mid-COMPRESS must be ignored
        start0 = 1'b1; num_samples = 16'd3; expected = 32'h04C11DB3;
        tick();
        start0 = 1'b0;
        chk("t4_done_drop", {31'h0, done0}, 32'h0);
        chk("t4_reseed",    sig0, 32'h0);
        chk("t4_cnt_clr",   {16'h0, cnt0}, 32'h0);
        data_in = 32'h00000001; tick();
        start0 = 1'b1; num_samples = 16'd1; expected = 32'h04C11DB2;
        data_in = 32'h80000000; tick();
        start0 = 1'b0;
        chk("t4_ign_sig",  sig0, 32'h80000002);
        chk("t4_ign_cnt",  {16'h0, cnt0}, 32'd2);
        chk("t4_ign_busy", {31'h0, busy0}, 32'h1);
        data_in = 32'h00000000; tick();
        chk("t4_sig",   sig0, 32'h04C11DB3);
        chk("t4_match", {31'h0, match0}, 32'h1);

        // Wrong golden value
        start0 = 1'b1; num_samples = 16'd3; expected = 32'h04C11DB2;
        tick();
        start0 = 1'b0;
        data_in = 32'h00000001; tick();
        data_in = 32'h80000000; tick();
        data_in = 32'h00000000; tick();
        chk("t6_done",  {31'h0, done0}, 32'h1);
        chk("t6_match", {31'h0, match0}, 32'h0);

        // N=0 with F=6: done immediately, signature stays at seed
        start1 = 1'b1; num_samples = 16'd0; expected = 32'hFFFFFFFF;
        tick();
        start1 = 1'b0;
        chk("t3_done",  {31'h0, done1}, 32'h1);
        chk("t3_busy",  {31'h0, busy1}, 32'h0);
        chk("t3_sig",   sig1, 32'hFFFFFFFF);
        chk("t3_match", {31'h0, match1}, 32'h1);

        // F=6, N=2 from DONE: busy for 8 cycles, flush data discarded
        start1 = 1'b1; num_samples = 16'd2; expected = 32'h12345678;
        tick();
        start1 = 1'b0;
        busy_cycles = 0;
        chk("t2_done_drop", {31'h0, done1}, 32'h0);
        chk("t2_cnt_clr",   {16'h0, cnt1}, 32'h0);
        if (busy1) busy_cycles++;
        for (int i = 0; i < 6; i++) begin
            data_in = 32'hDEADBEEF ^ 32'(i);
            tick();
            if (busy1) busy_cycles++;
        end
        chk("t2_flush_sig", sig1, 32'hFFFFFFFF);
        data_in = 32'hFB3EE249; tick();
        if (busy1) busy_cycles++;
        chk("t2_sig_a", sig1, 32'h00000000);
        data_in = 32'h12345678; tick();
        if (busy1) busy_cycles++;
        chk("t2_busy_len", 32'(busy_cycles), 32'd8);
        chk("t2_sig_b",  sig1, 32'h12345678);
        chk("t2_cnt",    {16'h0, cnt1}, 32'd2);
        chk("t2_done",   {31'h0, done1}, 32'h1);
        chk("t2_match",  {31'h0, match1}, 32'h1);

        // N=0 with a golden that differs from the seed
        start1 = 1'b1; num_samples = 16'd0; expected = 32'hFFFFFFFE;
        tick();
        start1 = 1'b0;
        chk("t3b_done",  {31'h0, done1}, 32'h1);
        chk("t3b_match", {31'h0, match1}, 32'h0);

        // Reset in the middle of COMPRESS
        start1 = 1'b1; num_samples = 16'd2; expected = 32'h12345678;
        tick();
        start1 = 1'b0;
        data_in = 32'hA5A5A5A5;
        for (int i = 0; i < 6; i++) tick();
        data_in = 32'hFB3EE249; tick();
        chk("t5_mid_sig", sig1, 32'h00000000);
        rst_n = 1'b0; tick();
        chk("t5_rst_sig",   sig1, 32'hFFFFFFFF);
        chk("t5_rst_busy",  {31'h0, busy1}, 32'h0);
        chk("t5_rst_done",  {31'h0, done1}, 32'h0);
        chk("t5_rst_match", {31'h0, match1}, 32'h0);
        chk("t5_rst_cnt",   {16'h0, cnt1}, 32'h0);
        rst_n = 1'b1; tick();
        chk("t5_idle_busy", {31'h0, busy1}, 32'h0);

        // Clean rerun after reset reproduces the clean signature
        start1 = 1'b1; num_samples = 16'd2; expected = 32'h12345678;
        tick();
        start1 = 1'b0;
        data_in = 32'h0BADF00D;
        for (int i = 0; i < 6; i++) tick();
        data_in = 32'hFB3EE249; tick();
        data_in = 32'h12345678; tick();
        chk("t5_rerun_sig",   sig1, 32'h12345678);
        chk("t5_rerun_match", {31'h0, match1}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mock_cpu_sig_checker
`default_nettype wire

// File: doc/mock_cpu_sig_checker.md
# mock_cpu_sig_checker

Downstream result checker for the `mock_cpu` pipeline. It consumes the CPU's registered `data_out` stream and compresses a programmable number of samples into a multiple-input signature register (MISR). It skips a fixed number of flush cycles first, then flags whether the final signature matches an expected value. It sits directly after `mock_cpu` in the Optuna sweep harness, so that every output bit has a timed, observable sink.

## Interface
- `DATA_WIDTH`, 32, width of the sample and the signature; must equal the CPU's `DATA_WIDTH`.
- `FLUSH_CYCLES`, 6, samples discarded after start (CPU `PIPELINE_DEPTH` + 2 register stages); 0 is legal.
- `CNT_WIDTH`, 16, width of the sample counter and `num_samples`.
- `MISR_POLY`, 32'h04C11DB7, feedback taps, `DATA_WIDTH` bits.
- `MISR_SEED`, 32'hFFFFFFFF, signature value at reset and at each start.

Ports:
- `clk`  in  1  the single clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle run request.
- `num_samples`  in  `CNT_WIDTH`  samples to compress; sampled on accepted `start`.
- `expected`  in  `DATA_WIDTH`  golden signature; sampled on accepted `start`.
- `data_in`  in  `DATA_WIDTH`  connects to `mock_cpu.data_out`.
- `busy`  out  1  high in FLUSH and COMPRESS.
- `done`  out  1  high in DONE.
- `match`  out  1  `done` && (`signature` == latched `expected`).
- `signature`  out  `DATA_WIDTH`  current MISR value.
- `sample_count`  out  `CNT_WIDTH`  samples folded in the current run.

## Operation
- FSM states: IDLE, FLUSH, COMPRESS, DONE.
- IDLE:
  - with `start`, go to FLUSH. If `FLUSH_CYCLES`==0, go to COMPRESS instead.
  - If the latched `num_samples`==0, go directly to DONE.
- FLUSH: a down-counter discards `data_in` for `FLUSH_CYCLES` cycles, then goes to COMPRESS. If `num_samples`==0, it goes to DONE instead.
- COMPRESS: each cycle, update the signature and increment `sample_count`. After the sample that makes `sample_count`==`num_samples`, go to DONE.
- MISR update: sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? `MISR_POLY` : 0) ^ `data_in`. All arithmetic is modulo 2 at `DATA_WIDTH` bits.
- DONE: `done` stays high and the signature is frozen. `start` restarts the run with the same transitions as from IDLE.
- Any accepted `start`:
  - sets the signature to `MISR_SEED` and `sample_count` to 0;
  - latches `num_samples` and `expected`.
- `start` is ignored in FLUSH and COMPRESS.
- `rst_n` low at a clock edge forces IDLE from any state, including mid-run, with these values:
  - `signature` = `MISR_SEED`
  - `sample_count` = 0
  - `busy` = `done` = `match` = 0
  - latched `expected` and `num_samples` = 0
- Reset has priority over `start`.

## Timing
- `start` is sampled at edge T. With F = `FLUSH_CYCLES` and N = `num_samples`:
  - `busy` is high for cycles T+1 .. T+F+N.
  - `data_in` is folded at edges T+F+1 .. T+F+N.
  - `done` and `match` are valid from cycle T+F+N+1.
- `signature` and `sample_count` are registered outputs with no combinational path from `data_in`.
- `match` is a compare of registered values, one comparator deep.
- Throughput is one sample per cycle, with no backpressure toward the CPU.

## Structure
- Put in `mock_cpu_pkg`:
  - the state enum `sig_state_e`;
  - default constants `MISR_POLY_DEFAULT` and `MISR_SEED_DEFAULT`.
- Sub-module `misr_step`: purely combinational, one-cycle MISR next-state function, parameterised on width and polynomial. It is reused by the upstream stimulus generator.
- The FSM, counters and latches live in the top module.

## Test plan
- Reset, `MISR_SEED`=0, F=0:
  - `start`, N=3, `data_in` = 32'h1, 32'h80000000, 32'h0.
  - Required signatures: 32'h1, then 32'h80000002, then 32'h04C11DB3.
  - `done` on the 4th cycle after `start`; `match`=1 with `expected`=32'h04C11DB3.
- F=6, N=2, default seed:
  - `busy` high for exactly 8 cycles.
  - Samples driven during flush leave the signature at 32'hFFFFFFFF.
  - `sample_count` ends at 2.
- N=0, F=6:
  - `done` from the cycle after `start`.
  - `signature`=`MISR_SEED`; `match`=1 iff `expected`==`MISR_SEED`.
- A second `start` pulse in COMPRESS is ignored; a `start` in DONE re-seeds, clears `sample_count` and drops `done` the next cycle.
- `rst_n` low mid-COMPRESS:
  - next cycle is IDLE with `signature`=`MISR_SEED`, `busy`=`done`=`match`=0;
  - a later run gives the same signature as a clean run.
- Wrong `expected` (golden XOR 1): `done`=1, `match`=0.
